// File: rtl/dpram_arbiter.sv
// Round-robin arbiter and read-return sequencer in front of a dual-port RAM.
// One write and one read per cycle; reads never race a same-cycle write to the same address.
module dpram_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wa_req,
    input  logic [AW-1:0]    wa_addr,
    input  logic [WIDTH-1:0] wa_data,
    output logic             wa_gnt,
    input  logic             wb_req,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_gnt,
    input  logic             ra_req,
    input  logic [AW-1:0]    ra_addr,
    output logic             ra_gnt,
    input  logic             rb_req,
    input  logic [AW-1:0]    rb_addr,
    output logic             rb_gnt,
    output logic             ra_valid,
    output logic             rb_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             ram_write,
    output logic             ram_read,
    output logic [AW-1:0]    ram_wr_addr,
    output logic [AW-1:0]    ram_rd_addr,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    logic             wptr;
    logic             rptr;
    logic             s1_b;
    logic [WIDTH-1:0] rd_hold;

    logic             w_any;
    logic             w_sel_b;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             r_any;
    logic             r_sel_b;
    logic [AW-1:0]    r_addr;
    logic             collide;
    logic             r_go;

    // Arbitration: pointer high favours B; a read loses to a same-address write.
    always_comb begin
        w_any   = wa_req | wb_req;
        w_sel_b = wb_req & (~wa_req | wptr);
        w_addr  = w_sel_b ? wb_addr : wa_addr;
        w_data  = w_sel_b ? wb_data : wa_data;
        r_any   = ra_req | rb_req;
        r_sel_b = rb_req & (~ra_req | rptr);
        r_addr  = r_sel_b ? rb_addr : ra_addr;
        collide = w_any & r_any & (w_addr == r_addr);
        r_go    = r_any & ~collide;
        wa_gnt  = rst & w_any & ~w_sel_b;
        wb_gnt  = rst & w_sel_b;
        ra_gnt  = rst & r_go & ~r_sel_b;
        rb_gnt  = rst & r_go & r_sel_b;
        rd_data = (ra_valid | rb_valid) ? ram_data_out : rd_hold;
    end

    // Command registers, read tag pipeline and return-data hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            ram_write   <= 1'b0;
            ram_wr_addr <= '0;
            ram_data_in <= '0;
            ram_read    <= 1'b0;
            ram_rd_addr <= '0;
            s1_b        <= 1'b0;
            ra_valid    <= 1'b0;
            rb_valid    <= 1'b0;
            rd_hold     <= '0;
        end else begin
            ram_write <= w_any;
            if (w_any) begin
                ram_wr_addr <= w_addr;
                ram_data_in <= w_data;
                wptr        <= ~w_sel_b;
            end
            ram_read <= r_go;
            if (r_go) begin
                ram_rd_addr <= r_addr;
                s1_b        <= r_sel_b;
                rptr        <= ~r_sel_b;
            end
            ra_valid <= ram_read & ~s1_b;
            rb_valid <= ram_read & s1_b;
            if (ra_valid | rb_valid) begin
                rd_hold <= ram_data_out;
            end
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: RAM model, directed scenarios and randomized traffic
// checked against a transaction-level model (shadow memory plus return queue).
module tb_dpram_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wa_req, wb_req, ra_req, rb_req;
    logic [AW-1:0]    wa_addr, wb_addr, ra_addr, rb_addr;
    logic [WIDTH-1:0] wa_data, wb_data;
    logic             wa_gnt, wb_gnt, ra_gnt, rb_gnt;
    logic             ra_valid, rb_valid;
    logic [WIDTH-1:0] rd_data;
    logic             ram_write, ram_read;
    logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
    logic [WIDTH-1:0] ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    dpram_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wa_req(wa_req), .wa_addr(wa_addr), .wa_data(wa_data), .wa_gnt(wa_gnt),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
        .ra_req(ra_req), .ra_addr(ra_addr), .ra_gnt(ra_gnt),
        .rb_req(rb_req), .rb_addr(rb_addr), .rb_gnt(rb_gnt),
        .ra_valid(ra_valid), .rb_valid(rb_valid), .rd_data(rd_data),
        .ram_write(ram_write), .ram_read(ram_read),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // Dual-port RAM: registered read, data valid the cycle after ram_read.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_addr] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_rd_addr];
    end

    typedef struct {
        int               due;
        bit               is_b;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } rd_t;

    rd_t              rq[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               wfav_b, rfav_b;
    bit               exp_wr_v;
    logic [AW-1:0]    exp_wr_addr;
    logic [WIDTH-1:0] exp_wr_data;
    logic [WIDTH-1:0] exp_rd;
    bit               g_wa, g_wb, g_ra, g_rb;
    int               cyc;
    int               n_checks;
    int               n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: predict grants from the arbitration rules, check every output,
    // then commit accepted transactions into the model at the rising edge.
    task automatic step();
        bit               w_any, w_b, r_any, r_b, coll, rd_iss;
        logic [AW-1:0]    wad, rad;
        logic [WIDTH-1:0] wdat;
        rd_t              e;
        @(negedge clk);
        w_any = wa_req || wb_req;
        w_b   = wb_req && (!wa_req || wfav_b);
        wad   = w_b ? wb_addr : wa_addr;
        wdat  = w_b ? wb_data : wa_data;
        r_any = ra_req || rb_req;
        r_b   = rb_req && (!ra_req || rfav_b);
        rad   = r_b ? rb_addr : ra_addr;
        coll  = w_any && r_any && (wad == rad);
        g_wa  = w_any && !w_b;
        g_wb  = w_b;
        g_ra  = r_any && !coll && !r_b;
        g_rb  = r_any && !coll && r_b;
        check("wa_gnt", 32'(wa_gnt), 32'(g_wa));
        check("wb_gnt", 32'(wb_gnt), 32'(g_wb));
        check("ra_gnt", 32'(ra_gnt), 32'(g_ra));
        check("rb_gnt", 32'(rb_gnt), 32'(g_rb));
        check("ram_write", 32'(ram_write), 32'(exp_wr_v));
        if (exp_wr_v) begin
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(exp_wr_addr));
            check("ram_data_in", 32'(ram_data_in), 32'(exp_wr_data));
        end
        rd_iss = 1'b0;
        foreach (rq[i]) begin
            if (rq[i].due == cyc + 1) begin
                rd_iss = 1'b1;
                check("ram_rd_addr", 32'(ram_rd_addr), 32'(rq[i].addr));
            end
        end
        check("ram_read", 32'(ram_read), 32'(rd_iss));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("ra_valid", 32'(ra_valid), 32'(!rq[0].is_b));
            check("rb_valid", 32'(rb_valid), 32'(rq[0].is_b));
            exp_rd = rq[0].data;
            void'(rq.pop_front());
        end else begin
            check("ra_valid_idle", 32'(ra_valid), 32'(0));
            check("rb_valid_idle", 32'(rb_valid), 32'(0));
        end
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        @(posedge clk);
        if (g_ra || g_rb) begin
            e.due  = cyc + 2;
            e.is_b = g_rb;
            e.addr = rad;
            e.data = ref_mem[rad];
            rq.push_back(e);
            rfav_b = g_ra;
        end
        exp_wr_v = w_any;
        if (w_any) begin
            exp_wr_addr  = wad;
            exp_wr_data  = wdat;
            ref_mem[wad] = wdat;
            wfav_b       = g_wa;
        end
        cyc++;
        #1;
    endtask

    // Hold reset for a number of cycles; everything observable must read zero.
    task automatic do_reset(input int cycles);
        rst = 1'b0;
        rq.delete();
        exp_wr_v = 1'b0;
        exp_rd   = '0;
        wfav_b   = 1'b0;
        rfav_b   = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_gnts", 32'({wa_gnt, wb_gnt, ra_gnt, rb_gnt}), 32'(0));
            check("rst_valids", 32'({ra_valid, rb_valid}), 32'(0));
            check("rst_ram_en", 32'({ram_write, ram_read}), 32'(0));
            check("rst_addrs", 32'({ram_wr_addr, ram_rd_addr}), 32'(0));
            check("rst_data_in", 32'(ram_data_in), 32'(0));
            check("rst_rd_data", 32'(rd_data), 32'(0));
            @(posedge clk);
            cyc++;
            #1;
        end
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        wa_req = 1'b0; wb_req = 1'b0; ra_req = 1'b0; rb_req = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        exp_rd   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        wa_req = 1'b1; wb_req = 1'b1; ra_req = 1'b1; rb_req = 1'b1;
        wa_addr = 4'd0; wb_addr = 4'd1; ra_addr = 4'd2; rb_addr = 4'd3;
        wa_data = 8'hA0; wb_data = 8'hB0;
        #1;
        do_reset(3);

        // Every requester active straight out of reset: A wins both ports.
        step();
        idle(3);

        // Write 0x5A to 3, read it back two cycles later.
        wa_req = 1'b1; wa_addr = 4'd3; wa_data = 8'h5A;
        step();
        idle(1);
        ra_req = 1'b1; ra_addr = 4'd3;
        step();
        idle(3);

        // Same-address write and read in one cycle; read retries next cycle.
        wa_req = 1'b1; wa_addr = 4'd5; wa_data = 8'h11;
        ra_req = 1'b1; ra_addr = 4'd5;
        step();
        wa_req = 1'b0;
        step();
        idle(3);

        // Preload 1 and 2, realign the read pointer to A, then contend for reads.
        wa_req = 1'b1; wa_addr = 4'd1; wa_data = 8'h01;
        step();
        wa_addr = 4'd2; wa_data = 8'h02;
        step();
        wa_req = 1'b0;
        rb_req = 1'b1; rb_addr = 4'd0;
        step();
        ra_req = 1'b1; ra_addr = 4'd1; rb_req = 1'b1; rb_addr = 4'd2;
        repeat (4) step();
        idle(3);

        // Both writers contend for six cycles covering addresses 0..5.
        wa_req = 1'b1; wa_addr = 4'd0; wa_data = 8'hC0;
        wb_req = 1'b1; wb_addr = 4'd1; wb_data = 8'hD1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (g_wa) begin wa_addr = wa_addr + 4'd2; wa_data = wa_data + 8'd2; end
            if (g_wb) begin wb_addr = wb_addr + 4'd2; wb_data = wb_data + 8'd2; end
        end
        idle(2);

        // Reset while a read is in flight: its return must never appear.
        ra_req = 1'b1; ra_addr = 4'd7;
        step();
        ra_req = 1'b0;
        do_reset(2);
        idle(4);

        // Randomized traffic; each requester holds its request until granted.
        g_wa = 1'b0; g_wb = 1'b0; g_ra = 1'b0; g_rb = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (!wa_req || g_wa) begin
                wa_req = ($urandom_range(0, 3) != 0); wa_addr = rand_addr(); wa_data = WIDTH'($urandom);
            end
            if (!wb_req || g_wb) begin
                wb_req = ($urandom_range(0, 3) != 0); wb_addr = rand_addr(); wb_data = WIDTH'($urandom);
            end
            if (!ra_req || g_ra) begin
                ra_req = ($urandom_range(0, 2) != 0); ra_addr = rand_addr();
            end
            if (!rb_req || g_rb) begin
                rb_req = ($urandom_range(0, 2) != 0); rb_addr = rand_addr();
            end
            step();
        end
        idle(4);
        check("returns_drained", 32'(rq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Two-requester arbiter and sequencer in front of the 8-bit × 16-entry dual-port RAM (`dualport`). It shares the RAM write port between writers A and B, and the read port between readers A and B. Both ports use independent round-robin arbitration. The block registers all RAM commands, returns read data with a per-reader valid strobe, and blocks a read from observing a same-cycle write to the same address. It sits between the client logic and the RAM instance; clients never drive the RAM directly.

## Interface
- WIDTH, 8, data width (matches RAM)
- AW, 4, address width; RAM depth is 2**AW = 16
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wa_req / wb_req  in  1  write request from A / B
- wa_addr / wb_addr  in  AW  write address
- wa_data / wb_data  in  WIDTH  write data
- wa_gnt / wb_gnt  out  1  write accepted this cycle (combinational)
- ra_req / rb_req  in  1  read request from A / B
- ra_addr / rb_addr  in  AW  read address
- ra_gnt / rb_gnt  out  1  read accepted this cycle (combinational)
- ra_valid / rb_valid  out  1  rd_data belongs to A / B this cycle
- rd_data  out  WIDTH  read data (shared return bus)
- ram_write, ram_read  out  1  RAM port enables (registered)
- ram_wr_addr, ram_rd_addr  out  AW  RAM addresses (registered)
- ram_data_in  out  WIDTH  RAM write data (registered)
- ram_data_out  in  WIDTH  RAM read data; valid the cycle after ram_read

## Operation
- Handshake: a transfer occurs on any rising edge where req=1 and gnt=1.
  - A requester holds req, addr and data stable until it sees gnt.
  - It may present a new request on the very next cycle.
- gnt is combinational from req and internal state. gnt never asserts without req.
- Write arbitration:
  - Write pointer wptr ∈ {A,B} selects the favoured writer.
  - If only one writer requests, it wins.
  - If both request, the writer named by wptr wins.
  - After each grant, wptr points to the other writer.
- Read arbitration uses the same scheme with pointer rptr.
- Collision guard: if the winning read address equals the winning write address in the same cycle, no read grant is issued that cycle.
  - The read stays pending.
  - rptr does not change.
  - The write proceeds normally.
- Write issue: an accepted write drives ram_write=1 with its address and data on the cycle after acceptance. Otherwise ram_write=0.
- Read pipeline: stage 1 issues ram_read and ram_rd_addr. Stage 2 receives ram_data_out.
  - The requester tag (A/B) travels with the read through both stages.
- Read return: rd_data = ram_data_out whenever a valid read is in stage 2. The matching ra_valid/rb_valid is asserted for exactly one cycle.
  - At most one valid is high per cycle.
  - When no valid is asserted, rd_data holds its last value.
- Throughput: one write and one read per cycle.

## Timing
- Reset (rst=0, asynchronous):
  - ram_write, ram_read, all valids and the stage-1/stage-2 valid flags clear to 0.
  - ram_wr_addr, ram_rd_addr, ram_data_in and rd_data clear to 0.
  - wptr and rptr point to A.
  - gnt outputs are 0 while rst=0.
- Reset mid-operation: in-flight reads are discarded. No valid asserts after rst is released until a new read is accepted.
- Write latency: accepted at edge N → ram_write high during cycle N+1 → RAM commits at edge N+1.
- Read latency: accepted at edge N → ram_read high in cycle N+1 → valid and rd_data in cycle N+2 (two cycles).
- A read accepted at edge ≥ N+1 after a write accepted at edge N to the same address returns the new data.
- Because of the collision guard, a same-edge read to the same address is accepted at edge N+1 at the earliest.
- Address wrap: none inside the block. Addresses pass straight through; 15 and 0 are treated like any other address.

## Test plan
- Reset:
  - Drive rst=0 with all req=1 → all gnt, valid, ram_write and ram_read are 0.
  - Release rst → first grants on each port go to A.
- Write then read:
  - wa_req addr=3 data=0x5A, accepted at edge N → ram_write=1, ram_wr_addr=3, ram_data_in=0x5A in cycle N+1.
  - ra_req addr=3 accepted at edge N+2 → ra_valid=1, rd_data=0x5A in cycle N+4.
- Fair writes: wa_req and wb_req held high for 6 cycles with addresses 0..5 → grants go A,B,A,B,A,B, one ram_write per cycle.
- Collision:
  - Same cycle: wa addr=5 data=0x11 and ra addr=5, with the RAM entry previously 0x00.
  - Required: wa_gnt=1 and ra_gnt=0 that cycle; ra_gnt=1 next cycle; rd_data=0x11 two cycles later.
- Fair reads:
  - ra_req addr=1 and rb_req addr=2 held for 4 cycles, with entries 1 and 2 preloaded to 0x01/0x02.
  - Required: valids alternate A,B,A,B in consecutive cycles, with rd_data 0x01,0x02,0x01,0x02.
- Reset mid-read:
  - Accept ra read addr=7, then pull rst low one cycle later → ra_valid never asserts.
  - rd_data=0 after release.
